conv_pool_sched: RTL

Sequencing controller for the 3x3-conv / ReLU / 2x2-max-pool MAC datapath. It walks every pooled output position of a feature map and, for each position, every input channel. For each step it requests a 4x4 input patch plus a weight set from the parsing/buffer stage, then pulses the MAC valid with first/last-channel markers. It tracks results in flight through the fixed MAC latency and emits an output-write strobe with the pooled-map address. It sits between the parsing-data buffer and the mac datapath.

---
 rtl/conv_pool_sched_if.sv | 49 ++++
 rtl/conv_pool_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/conv_pool_sched_if.sv
// Handshake bundle between the conv/pool scheduler, the patch buffer,
// the MAC datapath and the run controller.
interface conv_pool_sched_if #(
  parameter int MAX_W  = 256,
  parameter int MAX_H  = 256,
  parameter int MAX_CH = 64
) ();
  localparam int WW = $clog2(MAX_W + 1);
  localparam int HW = $clog2(MAX_H + 1);
  localparam int CW = $clog2(MAX_CH + 1);
  localparam int XW = $clog2(MAX_W);
  localparam int YW = $clog2(MAX_H);
  localparam int IW = $clog2(MAX_CH);
  localparam int AW = $clog2(MAX_W * MAX_H / 4);

  logic          start;
  logic [WW-1:0] cfg_width;
  logic [HW-1:0] cfg_height;
  logic [CW-1:0] cfg_ch;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic          rd_req;
  logic          rd_ack;
  logic [XW-1:0] patch_x;
  logic [YW-1:0] patch_y;
  logic [IW-1:0] ch_idx;
  logic          mac_vld;
  logic          mac_first;
  logic          mac_last;
  logic          out_wr;
  logic [AW-1:0] out_addr;

  modport master (
    input  start, cfg_width, cfg_height, cfg_ch, rd_ack,
    output busy, done, cfg_err, rd_req,
    output patch_x, patch_y, ch_idx,
    output mac_vld, mac_first, mac_last,
    output out_wr, out_addr
  );

  modport slave (
    output start, cfg_width, cfg_height, cfg_ch, rd_ack,
    input  busy, done, cfg_err, rd_req,
    input  patch_x, patch_y, ch_idx,
    input  mac_vld, mac_first, mac_last,
    input  out_wr, out_addr
  );
endinterface

// File: rtl/conv_pool_sched.sv
// Walks pooled positions and channels of a feature map, fetching patches
// and issuing MAC steps; tracks pooled results through the MAC latency.
module conv_pool_sched #(
  parameter int MAX_W   = 256,
  parameter int MAX_H   = 256,
  parameter int MAX_CH  = 64,
  parameter int MAC_LAT = 10
) (
  input logic clk,
  input logic rst,
  conv_pool_sched_if.master bus
);
  localparam int WW = $clog2(MAX_W + 1);
  localparam int HW = $clog2(MAX_H + 1);
  localparam int CW = $clog2(MAX_CH + 1);
  localparam int XW = $clog2(MAX_W);
  localparam int YW = $clog2(MAX_H);
  localparam int IW = $clog2(MAX_CH);
  localparam int AW = $clog2(MAX_W * MAX_H / 4);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, DRAIN, DONE
  } state_t;

  state_t state, nxt;

  logic [XW-1:0] px, pw;
  logic [YW-1:0] py, ph;
  logic [IW-1:0] ch;
  logic [CW-1:0] ch_n;
  logic [AW-1:0] addr;
  logic          cfg_err_q;

  logic [MAC_LAT-1:0] dl_v;
  logic [AW-1:0]      dl_a [MAC_LAT];
  logic [MAC_LAT-1:0] body;

  logic legal, accept, pending;
  logic last_ch, last_px, last_py;
  logic vld, last;

  assign legal = !bus.cfg_width[0]
              && bus.cfg_width >= WW'(4)
              && bus.cfg_width <= WW'(MAX_W)
              && !bus.cfg_height[0]
              && bus.cfg_height >= HW'(4)
              && bus.cfg_height <= HW'(MAX_H)
              && bus.cfg_ch >= CW'(1)
              && bus.cfg_ch <= CW'(MAX_CH);

  assign accept  = (state == IDLE) && bus.start && legal;
  assign last_ch = (CW'(ch) == ch_n - CW'(1));
  assign last_px = (px == pw - XW'(1));
  assign last_py = (py == ph - YW'(1));
  assign vld     = (state == ISSUE);
  assign last    = vld && last_ch;

  // DONE must coincide with the cycle after the final tail write,
  // so only entries behind the tail keep DRAIN waiting.
  always_comb begin
    body = dl_v;
    body[MAC_LAT-1] = 1'b0;
    pending = |body;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (accept) nxt = FETCH;
      FETCH: if (bus.rd_ack) nxt = ISSUE;
      ISSUE: nxt = (last_ch && last_px && last_py) ? DRAIN : FETCH;
      DRAIN: if (!pending) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px        <= '0;
      py        <= '0;
      ch        <= '0;
      addr      <= '0;
      pw        <= '0;
      ph        <= '0;
      ch_n      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state == IDLE) && bus.start && !legal;
      if (accept) begin
        pw   <= XW'((bus.cfg_width - WW'(2)) >> 1);
        ph   <= YW'((bus.cfg_height - HW'(2)) >> 1);
        ch_n <= bus.cfg_ch;
        px   <= '0;
        py   <= '0;
        ch   <= '0;
        addr <= '0;
      end else if (vld) begin
        if (!last_ch) begin
          ch <= ch + IW'(1);
        end else begin
          ch   <= '0;
          addr <= (last_px && last_py) ? '0 : addr + AW'(1);
          if (!last_px) begin
            px <= px + XW'(1);
          end else begin
            px <= '0;
            py <= last_py ? '0 : py + YW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_v <= '0;
      for (int i = 0; i < MAC_LAT; i++) dl_a[i] <= '0;
    end else begin
      dl_v[0] <= last;
      dl_a[0] <= last ? addr : '0;
      for (int i = 1; i < MAC_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.cfg_err   = cfg_err_q;
  assign bus.rd_req    = (state == FETCH);
  assign bus.patch_x   = XW'({px, 1'b0});
  assign bus.patch_y   = YW'({py, 1'b0});
  assign bus.ch_idx    = ch;
  assign bus.mac_vld   = vld;
  assign bus.mac_first = vld && (ch == '0);
  assign bus.mac_last  = last;
  assign bus.out_wr    = dl_v[MAC_LAT-1];
  assign bus.out_addr  = dl_a[MAC_LAT-1];
endmodule
